// File: rtl/clk_enable_gen.sv
// Per-channel clock-enable generator gated by a synchronised PLL lock.
// After lock and a settle period, each channel pulses every N+1 cycles at phase offset P.
module clk_enable_gen #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned LOCK_WAIT   = 1024,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic [NUM_CH*DIV_W-1:0] phase_cfg,
    input  logic                    cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       ce_out,
    output logic                    locked,
    output logic                    cfg_ack
);

    localparam int unsigned SET_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [SYNC_STAGES-1:0]         r_sync;
    logic                           w_lk_s;
    logic [SET_W-1:0]               r_settle;
    logic [NUM_CH-1:0][DIV_W-1:0]   r_div;
    logic [NUM_CH-1:0][DIV_W-1:0]   r_ph;
    logic [NUM_CH-1:0][DIV_W-1:0]   r_cnt;
    logic [NUM_CH-1:0][DIV_W-1:0]   w_div_nxt;
    logic [NUM_CH-1:0][DIV_W-1:0]   w_ph_nxt;
    logic [NUM_CH-1:0][DIV_W-1:0]   w_pe_nxt;
    logic [NUM_CH-1:0][DIV_W-1:0]   w_cnt_nxt;
    logic [NUM_CH-1:0]              w_ce_nxt;
    logic                           w_run_nxt;
    logic                           w_reload;
    logic [NUM_CH-1:0]              r_ce;
    logic                           r_locked;
    logic                           r_ack;

    assign w_lk_s  = r_sync[SYNC_STAGES-1];
    assign ce_out  = r_ce;
    assign locked  = r_locked;
    assign cfg_ack = r_ack;

    // Lock-loss exit has priority over the settle-complete transition.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            WAIT_LOCK: if (w_lk_s) w_state_nxt = SETTLE;
            SETTLE: begin
                if (!w_lk_s)                  w_state_nxt = WAIT_LOCK;
                else if (r_settle == SET_LAST) w_state_nxt = RUN;
            end
            RUN:       if (!w_lk_s) w_state_nxt = WAIT_LOCK;
            default:   w_state_nxt = WAIT_LOCK;
        endcase
    end

    // Counters realign to the effective phase on RUN entry and on every config capture.
    always_comb begin
        w_run_nxt = (w_state_nxt == RUN);
        w_reload  = (r_state != RUN) || cfg_load;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_div_nxt[i] = cfg_load ? div_cfg[i*DIV_W +: DIV_W]   : r_div[i];
            w_ph_nxt[i]  = cfg_load ? phase_cfg[i*DIV_W +: DIV_W] : r_ph[i];
            w_pe_nxt[i]  = (w_ph_nxt[i] <= w_div_nxt[i]) ? w_ph_nxt[i] : w_div_nxt[i];
            if (!w_run_nxt || w_reload) begin
                w_cnt_nxt[i] = w_pe_nxt[i];
            end else if (r_cnt[i] == '0) begin
                w_cnt_nxt[i] = r_div[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] - DIV_W'(1);
            end
            w_ce_nxt[i] = w_run_nxt && (w_cnt_nxt[i] == '0) && ch_en[i];
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_sync   <= '0;
            r_state  <= WAIT_LOCK;
            r_settle <= '0;
            r_locked <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            r_state  <= w_state_nxt;
            r_settle <= (r_state == SETTLE) ? r_settle + SET_W'(1) : '0;
            r_locked <= (w_state_nxt == RUN);
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_ph  <= '0;
            r_cnt <= '0;
            r_ce  <= '0;
            r_ack <= 1'b0;
        end else begin
            r_div <= w_div_nxt;
            r_ph  <= w_ph_nxt;
            r_cnt <= w_cnt_nxt;
            r_ce  <= w_ce_nxt;
            r_ack <= cfg_load;
        end
    end

endmodule
